// File: rtl/ysyx_23060124_cache_pkg.sv
// Shared state encoding, AXI constants and address-geometry helpers
// for the set-associative instruction cache.
package ysyx_23060124_cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_AR,
    S_MISS_R,
    S_RESP,
    S_FLUSH
  } cache_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  function automatic int offset_bits(input int words_per_line, input int data_width);
    return $clog2(words_per_line * data_width / 8);
  endfunction

  function automatic int index_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int addr_width, input int words_per_line,
                                  input int data_width, input int sets);
    return addr_width - offset_bits(words_per_line, data_width) - index_bits(sets);
  endfunction

endpackage

// File: rtl/ysyx_23060124_icache_array.sv
// Tag, valid and data storage: all ways of one set are read in parallel,
// and a single way is written per cycle.
module ysyx_23060124_icache_array
  import ysyx_23060124_cache_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SETS           = 4,
  parameter int WAYS           = 2,
  parameter int WORDS_PER_LINE = 4,
  localparam int TAG_W  = tag_bits(ADDR_WIDTH, WORDS_PER_LINE, DATA_WIDTH, SETS),
  localparam int IDX_VW = (SETS > 1) ? index_bits(SETS) : 1,
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int WSEL_W = $clog2(WORDS_PER_LINE)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [IDX_VW-1:0]                set_idx,
  input  logic [WSEL_W-1:0]                rd_word,
  output logic [WAYS-1:0]                  rd_valid,
  output logic [WAYS-1:0][TAG_W-1:0]       rd_tag,
  output logic [WAYS-1:0][DATA_WIDTH-1:0]  rd_data,
  input  logic [WAY_W-1:0]                 wr_way,
  input  logic                             data_we,
  input  logic [WSEL_W-1:0]                wr_word,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic                             tag_we,
  input  logic [TAG_W-1:0]                 wr_tag,
  input  logic                             tag_valid
);

  logic [TAG_W-1:0]      tag_mem  [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_mem [SETS][WAYS][WORDS_PER_LINE];
  logic [SETS-1:0][WAYS-1:0] valid_q, valid_d;

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      rd_valid[w] = valid_q[set_idx][w];
      rd_tag[w]   = tag_mem[set_idx][w];
      rd_data[w]  = data_mem[set_idx][w][rd_word];
    end
  end

  // Flush wins over a same-cycle tag write so an invalidate-all is never partial.
  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else if (tag_we) begin
      valid_d[set_idx][wr_way] = tag_valid;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clock) begin
    if (data_we) begin
      data_mem[set_idx][wr_way][wr_word] <= wr_data;
    end
    if (tag_we) begin
      tag_mem[set_idx][wr_way] <= wr_tag;
    end
  end

endmodule

// File: rtl/ysyx_23060124_icache_sa.sv
// Blocking set-associative instruction cache with AXI4 burst refill,
// round-robin replacement and fence.i invalidate-all.
module ysyx_23060124_icache_sa
  import ysyx_23060124_cache_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SETS           = 4,
  parameter int WAYS           = 2,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  input  logic                  fence_i,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [3:0]            M_AXI_ARID,
  output logic [7:0]            M_AXI_ARLEN,
  output logic [2:0]            M_AXI_ARSIZE,
  output logic [1:0]            M_AXI_ARBURST,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY,
  input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RLAST
);

  localparam int BYTE_W = $clog2(DATA_WIDTH / 8);
  localparam int WSEL_W = $clog2(WORDS_PER_LINE);
  localparam int OFF_W  = offset_bits(WORDS_PER_LINE, DATA_WIDTH);
  localparam int TAG_W  = tag_bits(ADDR_WIDTH, WORDS_PER_LINE, DATA_WIDTH, SETS);
  localparam int IDX_VW = (SETS > 1) ? index_bits(SETS) : 1;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  cache_state_e                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]           araddr_q, araddr_d;
  logic [WAY_W-1:0]                victim_q, victim_d;
  logic [WSEL_W-1:0]               beat_q, beat_d;
  logic                            err_q, err_d;
  logic [SETS-1:0][WAY_W-1:0]      rr_q, rr_d;
  logic                            fence_pend_q, fence_pend_d;
  logic                            req_ready_q, req_ready_d;
  logic                            rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]           rsp_data_q, rsp_data_d;
  logic                            rsp_err_q, rsp_err_d;
  logic                            arvalid_q, arvalid_d;
  logic                            rready_q, rready_d;

  logic [IDX_VW-1:0]               set_idx;
  logic [WSEL_W-1:0]               word_sel;
  logic [TAG_W-1:0]                req_tag;
  logic [WAYS-1:0]                 rd_valid;
  logic [WAYS-1:0][TAG_W-1:0]      rd_tag;
  logic [WAYS-1:0][DATA_WIDTH-1:0] rd_data;
  logic                            hit;
  logic [DATA_WIDTH-1:0]           hit_data;
  logic [WAY_W-1:0]                victim_sel;
  logic                            flush, data_we, tag_we, tag_valid;
  logic                            beat_err, beat_last, fill_err;
  logic                            unused_addr_bits;

  generate
    if (SETS > 1) begin : g_idx
      assign set_idx = addr_q[OFF_W +: IDX_VW];
    end else begin : g_no_idx
      assign set_idx = '0;
    end
  endgenerate

  assign word_sel         = addr_q[BYTE_W +: WSEL_W];
  assign req_tag          = addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign unused_addr_bits = ^addr_q[BYTE_W-1:0];

  ysyx_23060124_icache_array #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .SETS          (SETS),
    .WAYS          (WAYS),
    .WORDS_PER_LINE(WORDS_PER_LINE)
  ) u_array (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .set_idx  (set_idx),
    .rd_word  (word_sel),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_way   (victim_q),
    .data_we  (data_we),
    .wr_word  (beat_q),
    .wr_data  (M_AXI_RDATA),
    .tag_we   (tag_we),
    .wr_tag   (req_tag),
    .tag_valid(tag_valid)
  );

  // Descending scan so the lowest-index invalid way is the one that sticks.
  always_comb begin
    hit        = 1'b0;
    hit_data   = '0;
    victim_sel = rr_q[set_idx];
    for (int w = 0; w < WAYS; w++) begin
      if (rd_valid[w] && (rd_tag[w] == req_tag)) begin
        hit      = 1'b1;
        hit_data = rd_data[w];
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!rd_valid[w]) begin
        victim_sel = WAY_W'(w);
      end
    end
  end

  assign beat_err  = (M_AXI_RRESP != RESP_OKAY);
  assign beat_last = (beat_q == WSEL_W'(WORDS_PER_LINE - 1));
  assign fill_err  = err_q | beat_err | (M_AXI_RLAST != beat_last);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    araddr_d    = araddr_q;
    victim_d    = victim_q;
    beat_d      = beat_q;
    err_d       = err_q;
    rr_d        = rr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    flush       = 1'b0;
    data_we     = 1'b0;
    tag_we      = 1'b0;
    tag_valid   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_ready_q) begin
          if (fence_i || fence_pend_q) begin
            state_d = S_FLUSH;
          end else if (req_valid) begin
            state_d = S_LOOKUP;
            addr_d  = req_addr;
          end
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = hit_data;
          rsp_err_d   = 1'b0;
        end else begin
          state_d   = S_MISS_AR;
          arvalid_d = 1'b1;
          araddr_d  = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
          victim_d  = victim_sel;
          err_d     = 1'b0;
          beat_d    = '0;
        end
      end
      S_MISS_AR: begin
        // The victim is invalidated before any beat lands so a failed or
        // abandoned refill can never expose a half-overwritten line.
        if (arvalid_q && M_AXI_ARREADY) begin
          state_d   = S_MISS_R;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          tag_we    = 1'b1;
        end
      end
      S_MISS_R: begin
        if (rready_q && M_AXI_RVALID) begin
          data_we = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (beat_err) begin
            err_d = 1'b1;
          end
          if (beat_q == word_sel) begin
            rsp_data_d = M_AXI_RDATA;
          end
          if (M_AXI_RLAST || beat_last) begin
            tag_we      = 1'b1;
            tag_valid   = !fill_err;
            rready_d    = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = fill_err;
            state_d     = S_RESP;
            if (!fill_err) begin
              rr_d[set_idx] = (rr_q[set_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[set_idx] + 1'b1;
            end
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = (fence_i || fence_pend_q) ? S_FLUSH : S_IDLE;
        end
      end
      S_FLUSH: begin
        flush   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d  = (state_d == S_IDLE);
    fence_pend_d = (fence_pend_q | fence_i) & (state_d != S_FLUSH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      araddr_q     <= '0;
      victim_q     <= '0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      rr_q         <= '0;
      fence_pend_q <= 1'b0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      araddr_q     <= araddr_d;
      victim_q     <= victim_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
      rr_q         <= rr_d;
      fence_pend_q <= fence_pend_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARID    = 4'd0;
  assign M_AXI_ARLEN   = 8'(WORDS_PER_LINE - 1);
  assign M_AXI_ARSIZE  = 3'(BYTE_W);
  assign M_AXI_ARBURST = BURST_INCR;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_ysyx_23060124_icache_sa.sv
// Directed bench for the instruction cache; a tiny AXI slave returns
// word_of(address) for every beat so expected fetch data is self-computed.
module tb_ysyx_23060124_icache_sa;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        fence_i = 1'b0;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY = 1'b0;
  logic [31:0] M_AXI_ARADDR;
  logic [3:0]  M_AXI_ARID;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic        M_AXI_RVALID = 1'b0;
  logic        M_AXI_RREADY;
  logic [31:0] M_AXI_RDATA = '0;
  logic [1:0]  M_AXI_RRESP = 2'b00;
  logic        M_AXI_RLAST = 1'b0;

  int checks = 0;
  int passes = 0;

  always #5 clock = ~clock;

  ysyx_23060124_icache_sa #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .SETS(4), .WAYS(2), .WORDS_PER_LINE(4)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .fence_i(fence_i),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
    .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
    .M_AXI_ARBURST(M_AXI_ARBURST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY), .M_AXI_RDATA(M_AXI_RDATA),
    .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hC0DE_0000;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_req(input logic [31:0] a);
    int n = 0;
    while (req_ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) $display("[TB] FAIL req_ready_wait @%h: got %b expected 1", a, req_ready);
    else passes++;
    req_valid = 1'b1;
    req_addr  = a;
    step();
    req_valid = 1'b0;
  endtask

  task automatic serve_fill(input logic [31:0] base, input int err_beat,
                            input int ar_delay, input int fence_beat);
    int n = 0;
    while (M_AXI_ARVALID !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (M_AXI_ARADDR !== base || M_AXI_ARVALID !== 1'b1)
      $display("[TB] FAIL ar_addr: got %h/%b expected %h/1", M_AXI_ARADDR, M_AXI_ARVALID, base);
    else passes++;
    for (int d = 0; d < ar_delay; d++) begin
      step();
      checks++;
      if (M_AXI_ARVALID !== 1'b1 || M_AXI_ARADDR !== base)
        $display("[TB] FAIL ar_hold cycle %0d: got %b/%h expected 1/%h", d, M_AXI_ARVALID, M_AXI_ARADDR, base);
      else passes++;
    end
    M_AXI_ARREADY = 1'b1;
    step();
    M_AXI_ARREADY = 1'b0;
    checks++;
    if (M_AXI_RREADY !== 1'b1 || M_AXI_ARVALID !== 1'b0)
      $display("[TB] FAIL r_phase: got rready=%b arvalid=%b expected 1/0", M_AXI_RREADY, M_AXI_ARVALID);
    else passes++;
    for (int k = 0; k < 4; k++) begin
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA  = word_of(base + 32'(4 * k));
      M_AXI_RRESP  = (k == err_beat) ? 2'b10 : 2'b00;
      M_AXI_RLAST  = (k == 3);
      fence_i      = (k == fence_beat);
      step();
      fence_i = 1'b0;
    end
    M_AXI_RVALID = 1'b0;
    M_AXI_RLAST  = 1'b0;
    M_AXI_RRESP  = 2'b00;
  endtask

  task automatic take_rsp(input logic [31:0] a, input logic exp_err);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1) $display("[TB] FAIL rsp_wait @%h: got %b expected 1", a, rsp_valid);
    else passes++;
    checks++;
    if (rsp_data !== word_of(a)) $display("[TB] FAIL rsp_data @%h: got %h expected %h", a, rsp_data, word_of(a));
    else passes++;
    checks++;
    if (rsp_err !== exp_err) $display("[TB] FAIL rsp_err @%h: got %b expected %b", a, rsp_err, exp_err);
    else passes++;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic full_miss(input logic [31:0] a, input int err_beat, input int fence_beat);
    do_req(a);
    step();
    checks++;
    if (M_AXI_ARVALID !== 1'b1 || rsp_valid !== 1'b0)
      $display("[TB] FAIL expect_miss @%h: got arvalid=%b rsp_valid=%b expected 1/0", a, M_AXI_ARVALID, rsp_valid);
    else passes++;
    serve_fill({a[31:4], 4'h0}, err_beat, 0, fence_beat);
    take_rsp(a, err_beat >= 0);
  endtask

  task automatic full_hit(input logic [31:0] a);
    do_req(a);
    checks++;
    if (rsp_valid !== 1'b0) $display("[TB] FAIL hit_early @%h: got %b expected 0", a, rsp_valid);
    else passes++;
    step();
    checks++;
    if (rsp_valid !== 1'b1 || M_AXI_ARVALID !== 1'b0)
      $display("[TB] FAIL expect_hit @%h: got rsp_valid=%b arvalid=%b expected 1/0", a, rsp_valid, M_AXI_ARVALID);
    else passes++;
    take_rsp(a, 1'b0);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if ({req_ready, rsp_valid, rsp_err, M_AXI_ARVALID, M_AXI_RREADY} !== 5'b0)
      $display("[TB] FAIL reset_ctrl: got %b expected 00000",
               {req_ready, rsp_valid, rsp_err, M_AXI_ARVALID, M_AXI_RREADY});
    else passes++;
    checks++;
    if (rsp_data !== 32'h0 || M_AXI_ARADDR !== 32'h0)
      $display("[TB] FAIL reset_data: got %h/%h expected 0/0", rsp_data, M_AXI_ARADDR);
    else passes++;
    checks++;
    if ({M_AXI_ARID, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST} !== {4'd0, 8'd3, 3'd2, 2'b01})
      $display("[TB] FAIL ar_consts: got %h expected %h",
               {M_AXI_ARID, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST}, {4'd0, 8'd3, 3'd2, 2'b01});
    else passes++;
    reset = 1'b0;
    step();
    checks++;
    if (req_ready !== 1'b1) $display("[TB] FAIL ready_after_reset: got %b expected 1", req_ready);
    else passes++;
  endtask

  task automatic test_cold_miss();
    do_req(32'h8000_0004);
    checks++;
    if (req_ready !== 1'b0) $display("[TB] FAIL ready_in_lookup: got %b expected 0", req_ready);
    else passes++;
    step();
    serve_fill(32'h8000_0000, -1, 2, -1);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h40DE_0004)
      $display("[TB] FAIL cold_word: got %b/%h expected 1/40de0004", rsp_valid, rsp_data);
    else passes++;
    take_rsp(32'h8000_0004, 1'b0);
  endtask

  task automatic test_hit_latency();
    do_req(32'h8000_0008);
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h40DE_0008 || M_AXI_ARVALID !== 1'b0)
      $display("[TB] FAIL hit_one_cycle: got %b/%h/%b expected 1/40de0008/0", rsp_valid, rsp_data, M_AXI_ARVALID);
    else passes++;
    take_rsp(32'h8000_0008, 1'b0);
  endtask

  task automatic test_eviction();
    reset_dut();
    full_miss(32'h8000_0000, -1, -1);
    full_miss(32'h8000_0040, -1, -1);
    full_miss(32'h8000_0080, -1, -1);
    full_hit(32'h8000_0040);
    full_miss(32'h8000_0000, -1, -1);
    full_hit(32'h8000_0084);
  endtask

  task automatic test_error();
    full_miss(32'h8000_0118, 2, -1);
    full_miss(32'h8000_0118, -1, -1);
    full_hit(32'h8000_011C);
  endtask

  task automatic test_fence();
    full_hit(32'h8000_0004);
    full_miss(32'h8000_0200, -1, 1);
    checks++;
    if (req_ready !== 1'b0) $display("[TB] FAIL flush_ready: got %b expected 0", req_ready);
    else passes++;
    step();
    checks++;
    if (req_ready !== 1'b1) $display("[TB] FAIL flush_done: got %b expected 1", req_ready);
    else passes++;
    full_miss(32'h8000_0004, -1, -1);
  endtask

  task automatic test_backpressure();
    do_req(32'h8000_0004);
    step();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h40DE_0004 || req_ready !== 1'b0)
        $display("[TB] FAIL hold cycle %0d: got %b/%h/%b expected 1/40de0004/0", c, rsp_valid, rsp_data, req_ready);
      else passes++;
      step();
    end
    take_rsp(32'h8000_0004, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    do_req(32'h8000_0308);
    step();
    M_AXI_ARREADY = 1'b1;
    step();
    M_AXI_ARREADY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA  = word_of(32'h8000_0300 + 32'(4 * k));
      reset        = (k == 2);
      step();
    end
    M_AXI_RVALID = 1'b0;
    checks++;
    if ({M_AXI_ARVALID, M_AXI_RREADY, rsp_valid, req_ready} !== 4'b0)
      $display("[TB] FAIL mid_burst_reset: got %b expected 0000",
               {M_AXI_ARVALID, M_AXI_RREADY, rsp_valid, req_ready});
    else passes++;
    reset = 1'b0;
    step();
    full_miss(32'h8000_0308, -1, -1);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_hit_latency();
    test_eviction();
    test_error();
    test_fence();
    test_backpressure();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
